// File: rtl/fifo_burst_arbiter_pkg.sv
// fifo_arb_pkg: shared types and helpers for the FIFO read-side burst arbiter.
//   arb_state_t : arbiter FSM encoding (IDLE, BURST, DONE)
//   addr_w/cnt_w/idx_w : width helpers for read address, occupancy and owner index
//   rr_pick     : round-robin one-hot selection over up to MAX_REQ requesters
package fifo_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      DONE  = 2'd2
   } arb_state_t;

   localparam int unsigned MAX_REQ = 8;
   localparam int unsigned PTR_W   = 3;

   function automatic int unsigned addr_w(input int unsigned depth);
      return $clog2(depth);
   endfunction

   function automatic int unsigned cnt_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic int unsigned idx_w(input int unsigned n);
      return $clog2(n);
   endfunction

   // First set bit at or after ptr, scanning upward and wrapping at n.
   function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                  input logic [PTR_W-1:0]   ptr,
                                                  input int unsigned        n);
      logic [MAX_REQ-1:0] pick;
      logic               found;
      logic [PTR_W-1:0]   sel;
      pick  = '0;
      found = 1'b0;
      for (int unsigned k = 0; k < MAX_REQ; k++) begin
         if (k < n) begin
            sel = PTR_W'((32'(ptr) + k) % n);
            if (!found && req[sel]) begin
               pick[sel] = 1'b1;
               found     = 1'b1;
            end
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/fifo_burst_arbiter_picker.sv
// fifo_rr_picker: combinational round-robin selector, shareable with the write side.
//   i_req    : request vector
//   i_ptr    : round-robin start position
//   o_onehot : selected requester, one-hot
//   o_idx    : binary index of the selected requester
//   o_any    : a requester was selected
module fifo_rr_picker
   import fifo_arb_pkg::*;
#(
   parameter int unsigned N_REQ = 4
) (
   input  logic [N_REQ-1:0]        i_req,
   input  logic [idx_w(N_REQ)-1:0] i_ptr,
   output logic [N_REQ-1:0]        o_onehot,
   output logic [idx_w(N_REQ)-1:0] o_idx,
   output logic                    o_any
);

   localparam int unsigned IDX_W = idx_w(N_REQ);

   logic [MAX_REQ-1:0] w_req_ext;
   logic [MAX_REQ-1:0] w_pick;

   always_comb begin
      w_req_ext              = '0;
      w_req_ext[N_REQ-1:0]   = i_req;
      w_pick                 = rr_pick(w_req_ext, PTR_W'(i_ptr), N_REQ);
      o_onehot               = w_pick[N_REQ-1:0];
      o_any                  = |w_pick;
      o_idx                  = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         if (w_pick[PTR_W'(k)]) begin
            o_idx = IDX_W'(k);
         end
      end
   end

endmodule

// File: rtl/fifo_burst_arbiter.sv
// fifo_burst_arbiter: shares the FIFO read port between N_REQ consumers using
// fixed-length read bursts granted round-robin. Owns the FIFO read pointer.
//   clk, rst   : clock, synchronous active-high reset (FIFO must reset alongside)
//   req        : per-requester burst request, level-sensitive
//   fifo_count : FIFO occupancy, sampled only while idle
//   grant      : one-hot burst owner, zero when idle
//   grant_idx  : binary owner index, holds last value when idle
//   rd_en      : FIFO read strobe, one word per cycle
//   rd_addr    : FIFO read address, valid with rd_en
//   busy       : high from grant through done
//   done       : one-cycle pulse after the last read of a burst
// Build option FIFO_ARB_PARTIAL_EN: when occupancy is below BURST_LEN but
// non-zero, grant a short burst of fifo_count beats instead of waiting.
module fifo_burst_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned N_REQ     = 4,
   parameter int unsigned BURST_LEN = 4,
   parameter int unsigned DEPTH     = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req,
   input  logic [cnt_w(DEPTH)-1:0] fifo_count,
   output logic [N_REQ-1:0]        grant,
   output logic [idx_w(N_REQ)-1:0] grant_idx,
   output logic                    rd_en,
   output logic [addr_w(DEPTH)-1:0] rd_addr,
   output logic                    busy,
   output logic                    done
);

   localparam int unsigned ADDR_W = addr_w(DEPTH);
   localparam int unsigned CNT_W  = cnt_w(DEPTH);
   localparam int unsigned IDX_W  = idx_w(N_REQ);
   localparam int unsigned BEAT_W = $clog2(BURST_LEN + 1);

   arb_state_t        r_state;
   logic [N_REQ-1:0]  r_grant;
   logic [IDX_W-1:0]  r_grant_idx;
   logic              r_rd_en;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [IDX_W-1:0]  r_rr_ptr;
   logic [BEAT_W-1:0] r_beat;
   logic [BEAT_W-1:0] r_last_beat;
   logic              r_busy;
   logic              r_done;

   logic              w_full_ok;
   logic [N_REQ-1:0]  w_eligible;
   logic [N_REQ-1:0]  w_pick;
   logic [IDX_W-1:0]  w_pick_idx;
   logic              w_any;

   assign w_full_ok = (fifo_count >= CNT_W'(BURST_LEN));

`ifdef FIFO_ARB_PARTIAL_EN
   // Any non-zero occupancy is enough; a short count becomes a short burst.
   assign w_eligible = (fifo_count != '0) ? req : '0;
`else
   assign w_eligible = w_full_ok ? req : '0;
`endif

   fifo_rr_picker #(
      .N_REQ(N_REQ)
   ) u_picker (
      .i_req   (w_eligible),
      .i_ptr   (r_rr_ptr),
      .o_onehot(w_pick),
      .o_idx   (w_pick_idx),
      .o_any   (w_any)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_grant     <= '0;
         r_grant_idx <= '0;
         r_rd_en     <= 1'b0;
         r_rd_ptr    <= '0;
         r_rr_ptr    <= '0;
         r_beat      <= '0;
         r_last_beat <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (w_any) begin
                  r_state     <= BURST;
                  r_grant     <= w_pick;
                  r_grant_idx <= w_pick_idx;
                  r_busy      <= 1'b1;
                  r_rd_en     <= 1'b1;
                  r_beat      <= '0;
`ifdef FIFO_ARB_PARTIAL_EN
                  r_last_beat <= w_full_ok ? BEAT_W'(BURST_LEN - 1)
                                           : BEAT_W'(fifo_count - CNT_W'(1));
`else
                  r_last_beat <= BEAT_W'(BURST_LEN - 1);
`endif
               end
            end
            BURST: begin
               r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
               r_beat   <= r_beat + BEAT_W'(1);
               if (r_beat == r_last_beat) begin
                  r_state <= DONE;
                  r_rd_en <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            DONE: begin
               r_state  <= IDLE;
               r_done   <= 1'b0;
               r_busy   <= 1'b0;
               r_grant  <= '0;
               r_rr_ptr <= (r_grant_idx == IDX_W'(N_REQ - 1)) ? '0
                                                              : r_grant_idx + IDX_W'(1);
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign grant     = r_grant;
   assign grant_idx = r_grant_idx;
   assign rd_en     = r_rd_en;
   assign rd_addr   = r_rd_ptr;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule
